// File: rtl/demux_router.sv
// demux_router: registered 1-to-N valid/ready demux with broadcast.
// Optional per-channel beat counters under `define DEMUX_ROUTER_STATS_EN.
module demux_router #(
   parameter int DATA_W = 8,
   parameter int N_OUT  = 4,
   parameter int SEL_W  = $clog2(N_OUT),
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_data,
   input  logic [SEL_W-1:0]          in_sel,
   input  logic                      in_bcast,
   output logic [N_OUT-1:0]          out_valid,
   input  logic [N_OUT-1:0]          out_ready,
   output logic [N_OUT*DATA_W-1:0]   out_data,
   input  logic                      stat_clr,
   output logic [N_OUT*CNT_W-1:0]    stat_cnt
);

   logic [N_OUT-1:0]        free;
   logic [N_OUT-1:0]        tgt;
   logic                    acc;
   logic [N_OUT-1:0]        valid_d, valid_q;
   logic [N_OUT*DATA_W-1:0] data_d, data_q;

   // Channel is free when empty or draining; broadcast needs every channel.
   always_comb begin
      free = ~valid_q | out_ready;
      tgt = '0;
      tgt[in_sel] = 1'b1;
      if (in_bcast) begin
         tgt = '1;
      end
      in_ready = in_bcast ? &free : free[in_sel];
      acc = in_valid && in_ready;
   end

   // Per channel: load on accept (pass-through), else drain, else hold.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      for (int k = 0; k < N_OUT; k++) begin
         if (acc && tgt[k]) begin
            valid_d[k] = 1'b1;
            data_d[k*DATA_W +: DATA_W] = in_data;
         end else if (valid_q[k] && out_ready[k]) begin
            valid_d[k] = 1'b0;
         end
      end
   end

   // Output registers; held beats are discarded on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

`ifdef DEMUX_ROUTER_STATS_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [N_OUT*CNT_W-1:0] cnt_d, cnt_q;

   // Saturating beat counters; clear wins over a same-cycle increment.
   always_comb begin
      cnt_d = cnt_q;
      for (int k = 0; k < N_OUT; k++) begin
         if (stat_clr) begin
            cnt_d[k*CNT_W +: CNT_W] = '0;
         end else if (acc && tgt[k] &&
                      cnt_q[k*CNT_W +: CNT_W] != CNT_MAX) begin
            cnt_d[k*CNT_W +: CNT_W] =
               cnt_q[k*CNT_W +: CNT_W] + CNT_ONE;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stat_cnt = cnt_q;
`else
   logic stats_unused;
   assign stats_unused = stat_clr;
   assign stat_cnt = '0;
`endif

endmodule

// File: doc/demux_router.md
# demux_router

Registered, flow-controlled 1-to-N demultiplexer. It is the parametrised successor of the combinational 4-way demux gate, generalised to a configurable data width and output-channel count. It adds a valid/ready handshake, a broadcast mode and optional per-channel beat counters. It sits between a single producer and N independent consumers, and each output channel stalls independently.

## Interface

Parameters:
- DATA_W, default 8: payload width in bits.
- N_OUT, default 4: number of output channels; must be a power of two and at least 2.
- SEL_W, default $clog2(N_OUT): select width; this parameter is derived and is not overridden.
- CNT_W, default 16: width of each statistics counter.

Ports:
- clk, input, 1: the single clock; all logic is on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: input beat present.
- in_ready, output, 1: the block accepts the beat this cycle.
- in_data, input, DATA_W: payload.
- in_sel, input, SEL_W: target channel for a unicast beat.
- in_bcast, input, 1: when 1, the beat goes to all channels and in_sel is ignored.
- out_valid, output, N_OUT: bit k means channel k holds a beat.
- out_ready, input, N_OUT: bit k means consumer k takes the beat this cycle.
- out_data, output, N_OUT*DATA_W: channel k occupies [k*DATA_W +: DATA_W].
- stat_clr, input, 1: synchronous clear of all counters.
- stat_cnt, output, N_OUT*CNT_W: channel k occupies [k*CNT_W +: CNT_W].

## Operation

- Each channel k has a one-entry output register made of out_valid[k] and its slice of out_data.
- free[k] = !out_valid[k] || out_ready[k]. A held beat is either absent or leaves this cycle.
- in_ready = in_bcast ? &free : free[in_sel].
  - in_ready is combinational from in_bcast, in_sel, out_valid and out_ready.
  - in_ready does not depend on in_valid.
- A beat is accepted when in_valid && in_ready. The target set is all channels for broadcast, otherwise channel in_sel only.
- For each channel k, in priority order:
  - Accept targets k: out_data[k] <= in_data and out_valid[k] <= 1. This includes the case where the old beat leaves the same cycle; the pass-through gives full throughput.
  - Otherwise, if out_valid[k] && out_ready[k]: out_valid[k] <= 0.
  - Otherwise: the channel holds.
- out_data[k] keeps its last value while out_valid[k] = 0. Consumers must qualify data with out_valid.
- A broadcast is all-or-nothing. No channel loads unless every channel is free in the same cycle.
- A held beat is never overwritten, never dropped and never duplicated.
- Channels drain independently. A stall on channel j does not block unicast traffic to any channel k ≠ j.
- Producer rule: in_data, in_sel and in_bcast stay stable while in_valid = 1 and in_ready = 0. The bench checks this; the RTL does not enforce it.

## Timing

- Latency is 1 cycle: a beat accepted at edge t is visible on out_valid and out_data after edge t.
- Throughput is one beat per cycle per channel while out_ready is held high.
- Reset (rst_n low, asynchronous) forces:
  - out_valid = 0.
  - out_data = 0.
  - stat_cnt = 0.
- During reset, in_ready reflects free[] and is therefore 1.
- Beats held when reset is asserted mid-operation are discarded. No output pulses on release.
- The first accept is possible on the first rising edge after rst_n deasserts.

## Configuration

- Macro: DEMUX_ROUTER_STATS_EN.
- Defined:
  - Per-channel counter k increments by 1 on each accept that targets k. A broadcast increments all channels.
  - Counters saturate at 2^CNT_W−1.
  - stat_clr zeroes all counters on the next edge. If a clear and an increment occur in the same cycle, the clear wins and the result is 0.
- Undefined:
  - No counter flops are built.
  - stat_cnt is tied to 0 and stat_clr is ignored.
  - The port list is unchanged.

## Test plan

- Reset and idle:
  - Stimulus: rst_n low for 3 cycles, then in_valid = 0.
  - Required: out_valid = 4'b0000, out_data = 0, stat_cnt = 0 and in_ready = 1.
- Unicast routing:
  - Stimulus: DATA_W = 8, N_OUT = 4, out_ready = 4'b1111. Send 0xA5 to sel 2, then 0x3C to sel 0 on consecutive cycles.
  - Required: out_valid = 4'b0100 with channel 2 = 0xA5 in cycle 1, then 4'b0001 with channel 0 = 0x3C in cycle 2.
- Back-pressure isolation:
  - Stimulus: out_ready[1] = 0. Send 0x11 to sel 1, then 0x22 to sel 1, then 0x33 to sel 3.
  - Required: 0x11 is held on channel 1; in_ready = 0 for 0x22; the bench then offers 0x33 to sel 3, which is accepted the next cycle. Raising out_ready[1] makes channel 1 deliver 0x11 exactly once, after which 0x22 is accepted.
- Broadcast all-or-nothing:
  - Stimulus: channel 3 is full and stalled, and a broadcast of 0x5A is offered.
  - Required: in_ready = 0 and no channel loads. Releasing out_ready[3] gives in_ready = 1, and all four channels show 0x5A with out_valid = 4'b1111 one cycle later.
- Full-rate pass-through:
  - Stimulus: 8 back-to-back beats 0x00–0x07 to sel 1 with out_ready[1] = 1.
  - Required: in_ready stays 1 and channel 1 outputs 0x00–0x07 on consecutive cycles, each one cycle late.
- Statistics (with DEMUX_ROUTER_STATS_EN, CNT_W = 2):
  - Stimulus: 5 unicast beats to channel 0 and 1 broadcast; then stat_clr in the same cycle as one accept to channel 0.
  - Required: channel 0 saturates at 3 and channels 1–3 read 1; after the clear, all counters read 0.
  - Without the macro, the same stimulus gives stat_cnt = 0 throughout.
